// File: rtl/dispatch_pkg.sv
// Shared widths, the buffered instruction record and the wakeup match
// used by dispatch_router and fu_dispatch_buf.
package dispatch_pkg;

    localparam int INST_ID_BITS = 6;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int FUC_BITS     = 2;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                 inst_id;
        logic [31:0]                             raw_instr;
        logic [63:0]                             pc;
        logic [MAX_OPERANDS-1:0]                 src_valid;
        logic [MAX_OPERANDS-1:0]                 src_ready;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   src_prn;
        logic [MAX_OPERANDS-1:0]                 dst_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   dst_prn;
    } dispatch_entry_t;

    // Apply one wakeup lane: every used source slot naming wk_prn
    // becomes ready; bits already set stay set.
    function automatic dispatch_entry_t wake_entry(
        input dispatch_entry_t     e,
        input logic                wk_vld,
        input logic [PRN_BITS-1:0] wk_prn
    );
        dispatch_entry_t r;
        r = e;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            if (wk_vld && e.src_valid[j] && (e.src_prn[j] == wk_prn)) begin
                r.src_ready[j] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_dispatch_buf.sv
// Single-FU FIFO with PRN wakeup snoop on every held and incoming entry.
// Ports: push_i/push_entry_i in, valid_o/head_o/occ_o out, pop on pop_ready_i.
module fu_dispatch_buf
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WK_N  = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  dispatch_entry_t               push_entry_i,
    input  logic                          pop_ready_i,
    input  logic [WK_N-1:0]               wk_vld_i,
    input  logic [WK_N-1:0][PRN_BITS-1:0] wk_prn_i,
    output logic                          valid_o,
    output logic                          full_o,
    output dispatch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0]    occ_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dispatch_entry_t  mem_q [DEPTH];
    dispatch_entry_t  mem_d [DEPTH];
    dispatch_entry_t  push_w;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic             pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == OCC_W'(DEPTH));
    assign occ_o   = cnt_q;
    // Empty slots are masked so idle payload outputs read as zero.
    assign head_o  = valid_o ? mem_q[rd_q] : '0;
    assign pop     = valid_o & pop_ready_i;

    always_comb begin
        push_w = push_entry_i;
        for (int k = 0; k < WK_N; k++) begin
            push_w = wake_entry(push_w, wk_vld_i[k], wk_prn_i[k]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            for (int k = 0; k < WK_N; k++) begin
                mem_d[i] = wake_entry(mem_d[i], wk_vld_i[k], wk_prn_i[k]);
            end
        end
        rd_d = rd_q;
        wr_d = wr_q;
        if (push_i) begin
            mem_d[wr_q] = push_w;
            wr_d        = bump(wr_q);
        end
        if (pop) begin
            rd_d = bump(rd_q);
        end
        cnt_d = cnt_q + OCC_W'(push_i) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/dispatch_router.sv
// Steers one renamed instruction per cycle to a per-class round-robin FU buffer.
// Ports: in_* handshake + payload, set_prn* wakeups, fu_* per-FU head outputs.
module dispatch_router
    import dispatch_pkg::*;
#(
    parameter int FU_COUNT  = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [FUC_BITS-1:0]         fu_class_cfg        [FU_COUNT],
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FUC_BITS-1:0]         in_fu_class,
    input  logic [INST_ID_BITS-1:0]     in_inst_id,
    input  logic [31:0]                 in_raw_instr,
    input  logic [63:0]                 in_instr_pc,
    input  logic                        in_prn_input_valid  [MAX_OPERANDS],
    input  logic                        in_prn_input_ready  [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]         in_prn_input        [MAX_OPERANDS],
    input  logic                        in_prn_output_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]         in_prn_output       [MAX_OPERANDS],
    input  logic                        set_prn_ready       [FU_COUNT][MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]         set_prn             [FU_COUNT][MAX_OPERANDS],
    output logic                        fu_valid            [FU_COUNT],
    input  logic                        fu_ready            [FU_COUNT],
    output logic [INST_ID_BITS-1:0]     fu_inst_id          [FU_COUNT],
    output logic [31:0]                 fu_raw_instr        [FU_COUNT],
    output logic [63:0]                 fu_instr_pc         [FU_COUNT],
    output logic                        fu_prn_input_valid  [FU_COUNT][MAX_OPERANDS],
    output logic                        fu_prn_input_ready  [FU_COUNT][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]         fu_prn_input        [FU_COUNT][MAX_OPERANDS],
    output logic                        fu_prn_output_valid [FU_COUNT][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]         fu_prn_output       [FU_COUNT][MAX_OPERANDS],
    output logic [$clog2(BUF_DEPTH+1)-1:0] fu_occupancy     [FU_COUNT]
);

    localparam int NCLS = 1 << FUC_BITS;
    localparam int WK_N = FU_COUNT * MAX_OPERANDS;
    localparam int FI_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FI_W-1:0]               rr_q [NCLS];
    logic [FI_W-1:0]               rr_d [NCLS];
    logic [FU_COUNT-1:0]           cand, full, push;
    logic [FI_W-1:0]               tgt;
    logic                          accept;
    logic [WK_N-1:0]               wk_vld;
    logic [WK_N-1:0][PRN_BITS-1:0] wk_prn;
    dispatch_entry_t               in_entry;
    dispatch_entry_t               head [FU_COUNT];

    always_comb begin
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                wk_vld[f*MAX_OPERANDS+k] = set_prn_ready[f][k];
                wk_prn[f*MAX_OPERANDS+k] = set_prn[f][k];
            end
        end
    end

    always_comb begin
        in_entry           = '0;
        in_entry.inst_id   = in_inst_id;
        in_entry.raw_instr = in_raw_instr;
        in_entry.pc        = in_instr_pc;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            in_entry.src_valid[j] = in_prn_input_valid[j];
            in_entry.src_ready[j] = in_prn_input_ready[j];
            in_entry.src_prn[j]   = in_prn_input[j];
            in_entry.dst_valid[j] = in_prn_output_valid[j];
            in_entry.dst_prn[j]   = in_prn_output[j];
        end
    end

    // Full FUs are excluded even when popping, keeping fu_ready off in_ready.
    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            cand[i] = (fu_class_cfg[i] == in_fu_class) && !full[i];
        end
    end

    assign in_ready = (|cand) & ~flush & ~rst;
    assign accept   = in_valid & in_ready;

    // First candidate at or after the class pointer, wrapping.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        tgt   = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            idx = int'(rr_q[in_fu_class]) + k;
            if (idx >= FU_COUNT) idx = idx - FU_COUNT;
            if (!found && cand[idx]) begin
                tgt   = FI_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d[in_fu_class] = (32'(tgt) == FU_COUNT - 1) ? '0 : tgt + 1'b1;
        end
        for (int i = 0; i < FU_COUNT; i++) begin
            push[i] = accept && (32'(tgt) == i);
        end
    end

    // Flush keeps the pointers; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCLS; c++) rr_q[c] <= '0;
        end else begin
            for (int c = 0; c < NCLS; c++) rr_q[c] <= rr_d[c];
        end
    end

    for (genvar g = 0; g < FU_COUNT; g++) begin : g_fu
        fu_dispatch_buf #(
            .DEPTH (BUF_DEPTH),
            .WK_N  (WK_N)
        ) u_buf (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (flush),
            .push_i       (push[g]),
            .push_entry_i (in_entry),
            .pop_ready_i  (fu_ready[g]),
            .wk_vld_i     (wk_vld),
            .wk_prn_i     (wk_prn),
            .valid_o      (fu_valid[g]),
            .full_o       (full[g]),
            .head_o       (head[g]),
            .occ_o        (fu_occupancy[g])
        );

        assign fu_inst_id[g]   = head[g].inst_id;
        assign fu_raw_instr[g] = head[g].raw_instr;
        assign fu_instr_pc[g]  = head[g].pc;

        for (genvar j = 0; j < MAX_OPERANDS; j++) begin : g_op
            assign fu_prn_input_valid[g][j]  = head[g].src_valid[j];
            assign fu_prn_input_ready[g][j]  = head[g].src_ready[j];
            assign fu_prn_input[g][j]        = head[g].src_prn[j];
            assign fu_prn_output_valid[g][j] = head[g].dst_valid[j];
            assign fu_prn_output[g][j]       = head[g].dst_prn[j];
        end
    end

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_dispatch_router;
    import dispatch_pkg::*;

    localparam int NF = 4;
    localparam int NO = MAX_OPERANDS;
    localparam int D  = 2;

    logic                    clk = 1'b0;
    logic                    rst, flush;
    logic [1:0]              cfg [NF];
    logic                    in_valid, in_ready;
    logic [1:0]              in_cls;
    logic [5:0]              in_id;
    logic [31:0]             in_raw;
    logic [63:0]             in_pc;
    logic                    ipv [NO], ipr [NO], opv [NO];
    logic [5:0]              ip [NO], op [NO];
    logic                    spr [NF][NO];
    logic [5:0]              sp [NF][NO];
    logic                    fv [NF], fr [NF];
    logic [5:0]              fid [NF];
    logic [31:0]             fraw [NF];
    logic [63:0]             fpc [NF];
    logic                    fipv [NF][NO], fipr [NF][NO], fopv [NF][NO];
    logic [5:0]              fip [NF][NO], fop [NF][NO];
    logic [1:0]              occ [NF];

    int n_cmp = 0;
    int n_err = 0;

    dispatch_router #(.FU_COUNT(NF), .BUF_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .fu_class_cfg(cfg),
        .in_valid(in_valid), .in_ready(in_ready), .in_fu_class(in_cls),
        .in_inst_id(in_id), .in_raw_instr(in_raw), .in_instr_pc(in_pc),
        .in_prn_input_valid(ipv), .in_prn_input_ready(ipr),
        .in_prn_input(ip), .in_prn_output_valid(opv), .in_prn_output(op),
        .set_prn_ready(spr), .set_prn(sp),
        .fu_valid(fv), .fu_ready(fr), .fu_inst_id(fid),
        .fu_raw_instr(fraw), .fu_instr_pc(fpc),
        .fu_prn_input_valid(fipv), .fu_prn_input_ready(fipr),
        .fu_prn_input(fip), .fu_prn_output_valid(fopv),
        .fu_prn_output(fop), .fu_occupancy(occ)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]            id;
        logic [31:0]           raw;
        logic [63:0]           pc;
        logic [NO-1:0]         sv, sr, dv;
        logic [NO-1:0][5:0]    sp, dp;
    } ment_t;

    ment_t mq [NF][$];
    int    rr [4];

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic bit m_cand(int i);
        return (cfg[i] == in_cls) && (mq[i].size() < D);
    endfunction

    function automatic bit m_ready();
        bit any = 0;
        for (int i = 0; i < NF; i++) if (m_cand(i)) any = 1;
        return any && !flush && !rst;
    endfunction

    function automatic ment_t m_wake(ment_t e);
        ment_t r = e;
        for (int j = 0; j < NO; j++)
            for (int f = 0; f < NF; f++)
                for (int k = 0; k < NO; k++)
                    if (e.sv[j] && spr[f][k] && sp[f][k] == e.sp[j]) r.sr[j] = 1'b1;
        return r;
    endfunction

    function automatic ment_t cur_entry();
        ment_t n;
        n.id = in_id; n.raw = in_raw; n.pc = in_pc;
        for (int j = 0; j < NO; j++) begin
            n.sv[j] = ipv[j]; n.sr[j] = ipr[j]; n.sp[j] = ip[j];
            n.dv[j] = opv[j]; n.dp[j] = op[j];
        end
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NF; i++) mq[i].delete();
        for (int c = 0; c < 4; c++) rr[c] = 0;
    endtask

    task automatic m_step();
        bit acc;
        int tgt, i;
        acc = in_valid && m_ready();
        tgt = -1;
        for (int k = 0; k < NF; k++) begin
            i = (rr[in_cls] + k) % NF;
            if (tgt < 0 && m_cand(i)) tgt = i;
        end
        if (rst) begin
            m_reset();
        end else if (flush) begin
            for (int q = 0; q < NF; q++) mq[q].delete();
        end else begin
            for (int q = 0; q < NF; q++)
                if (mq[q].size() > 0 && fr[q]) void'(mq[q].pop_front());
            for (int q = 0; q < NF; q++)
                for (int e = 0; e < mq[q].size(); e++) mq[q][e] = m_wake(mq[q][e]);
            if (acc) begin
                mq[tgt].push_back(m_wake(cur_entry()));
                rr[in_cls] = (tgt + 1) % NF;
            end
        end
    endtask

    task automatic m_check(string tag);
        logic [NO-1:0] a_sr, a_sv;
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("%s valid[%0d]", tag, i), 64'(fv[i]), 64'(mq[i].size() > 0));
            chk($sformatf("%s occ[%0d]", tag, i), 64'(occ[i]), 64'(mq[i].size()));
            if (mq[i].size() > 0) begin
                for (int j = 0; j < NO; j++) begin
                    a_sr[j] = fipr[i][j];
                    a_sv[j] = fipv[i][j];
                end
                chk($sformatf("%s id[%0d]", tag, i), 64'(fid[i]), 64'(mq[i][0].id));
                chk($sformatf("%s pc[%0d]", tag, i), fpc[i], mq[i][0].pc);
                chk($sformatf("%s raw[%0d]", tag, i), 64'(fraw[i]), 64'(mq[i][0].raw));
                chk($sformatf("%s srcv[%0d]", tag, i), 64'(a_sv), 64'(mq[i][0].sv));
                chk($sformatf("%s srdy[%0d]", tag, i), 64'(a_sr), 64'(mq[i][0].sr));
                chk($sformatf("%s sprn0[%0d]", tag, i), 64'(fip[i][0]), 64'(mq[i][0].sp[0]));
                chk($sformatf("%s dprn2[%0d]", tag, i), 64'(fop[i][2]), 64'(mq[i][0].dp[2]));
            end else begin
                chk($sformatf("%s idle id[%0d]", tag, i), 64'(fid[i]), 64'd0);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; in_cls = '0; in_id = '0;
        in_raw = '0; in_pc = '0;
        for (int j = 0; j < NO; j++) begin
            ipv[j] = 0; ipr[j] = 0; ip[j] = '0; opv[j] = 0; op[j] = '0;
        end
        for (int i = 0; i < NF; i++) begin
            fr[i] = 0;
            for (int k = 0; k < NO; k++) begin
                spr[i][k] = 0; sp[i][k] = '0;
            end
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        in_cls = cfg[0];
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        cyc();
        rst = 0;
        in_cls = '0;
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("reset valid[%0d]", i), 64'(fv[i]), 64'd0);
            chk($sformatf("reset occ[%0d]", i), 64'(occ[i]), 64'd0);
            chk($sformatf("reset pc[%0d]", i), fpc[i], 64'd0);
        end
        m_reset();
    endtask

    task automatic push(logic [1:0] c, logic [5:0] id, logic exp_rdy, string n);
        in_valid = 1; in_cls = c; in_id = id;
        in_pc = 64'h1000 + 64'(id);
        #1;
        chk(n, 64'(in_ready), 64'(exp_rdy));
    endtask

    task automatic rand_in();
        in_valid = ($urandom_range(9) < 7);
        in_cls   = 2'($urandom_range(3));
        in_id    = 6'($urandom);
        in_raw   = $urandom;
        in_pc    = {$urandom, $urandom};
        for (int j = 0; j < NO; j++) begin
            ipv[j] = 1'($urandom_range(1));
            ipr[j] = ($urandom_range(3) == 0);
            ip[j]  = 6'($urandom_range(7));
            opv[j] = 1'($urandom_range(1));
            op[j]  = 6'($urandom);
        end
        for (int i = 0; i < NF; i++) begin
            fr[i] = ($urandom_range(9) < 6);
            for (int k = 0; k < NO; k++) begin
                spr[i][k] = ($urandom_range(9) == 0);
                sp[i][k]  = 6'($urandom_range(7));
            end
        end
        flush = ($urandom_range(49) == 0);
        rst   = ($urandom_range(199) == 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] cfg;
        logic [1:0] cls;
        logic [5:0] id;
        logic       rdy;
        int         fu;
    } vec_t;

    vec_t vt [6];
    int   exp_occ [NF];

    initial begin
        rst = 1;
        for (int i = 0; i < NF; i++) cfg[i] = 2'(i);
        idle();
        @(negedge clk);

        vt[0] = '{8'hE4, 2'd2, 6'd5,  1'b1, 2};
        vt[1] = '{8'hE4, 2'd0, 6'd9,  1'b1, 0};
        vt[2] = '{8'h50, 2'd3, 6'd4,  1'b0, -1};
        vt[3] = '{8'h50, 2'd1, 6'd7,  1'b1, 2};
        vt[4] = '{8'h50, 2'd2, 6'd8,  1'b0, -1};
        vt[5] = '{8'hFF, 2'd3, 6'd33, 1'b1, 0};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NF; i++) cfg[i] = vt[v].cfg[2*i +: 2];
            do_reset();
            push(vt[v].cls, vt[v].id, vt[v].rdy, $sformatf("vec%0d in_ready", v));
            cyc();
            idle();
            for (int i = 0; i < NF; i++) begin
                chk($sformatf("vec%0d valid[%0d]", v, i), 64'(fv[i]), 64'(i == vt[v].fu));
                chk($sformatf("vec%0d occ[%0d]", v, i), 64'(occ[i]), 64'(i == vt[v].fu));
            end
            if (vt[v].fu >= 0)
                chk($sformatf("vec%0d id", v), 64'(fid[vt[v].fu]), 64'(vt[v].id));
        end

        // Unmapped class held for several cycles; readiness ignores in_valid.
        for (int i = 0; i < NF; i++) cfg[i] = (i < 2) ? 2'd0 : 2'd1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            push(2'd3, 6'd1, 1'b0, "unmapped in_ready");
            cyc();
        end
        idle();
        for (int i = 0; i < NF; i++) chk("unmapped occ", 64'(occ[i]), 64'd0);
        in_cls = 2'd1;
        #1;
        chk("ready without valid", 64'(in_ready), 64'd1);

        // Round robin across three class-0 FUs.
        cfg[0] = 0; cfg[1] = 0; cfg[2] = 0; cfg[3] = 1;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push(2'd0, 6'(p + 1), 1'b1, "rr in_ready");
            cyc();
        end
        idle();
        exp_occ = '{2, 1, 1, 0};
        for (int i = 0; i < NF; i++)
            chk($sformatf("rr occ[%0d]", i), 64'(occ[i]), 64'(exp_occ[i]));
        chk("rr head0", 64'(fid[0]), 64'd1);
        chk("rr head1", 64'(fid[1]), 64'd2);
        chk("rr head2", 64'(fid[2]), 64'd3);
        fr[0] = 1;
        cyc();
        fr[0] = 0;
        chk("rr fifo order", 64'(fid[0]), 64'd4);
        chk("rr occ after pop", 64'(occ[0]), 64'd1);

        // Backpressure: full FU stays blocked in the cycle it pops.
        for (int i = 0; i < NF; i++) cfg[i] = 2'(i);
        do_reset();
        push(2'd3, 6'd1, 1'b1, "bp push1"); cyc();
        push(2'd3, 6'd2, 1'b1, "bp push2"); cyc();
        push(2'd3, 6'd3, 1'b0, "bp full");
        fr[3] = 1;
        #1;
        chk("bp full while popping", 64'(in_ready), 64'd0);
        cyc();
        fr[3] = 0;
        chk("bp occ after pop", 64'(occ[3]), 64'd1);
        chk("bp head after pop", 64'(fid[3]), 64'd2);
        push(2'd3, 6'd3, 1'b1, "bp ready again");
        cyc();
        idle();
        chk("bp occ refill", 64'(occ[3]), 64'd2);
        chk("bp head held", 64'(fid[3]), 64'd2);

        // Wakeup while buffered, and in the push cycle.
        do_reset();
        ipv[0] = 1; ipr[0] = 0; ip[0] = 6'd17;
        push(2'd1, 6'd11, 1'b1, "wk push");
        cyc();
        idle();
        chk("wk not yet ready", 64'(fipr[1][0]), 64'd0);
        spr[1][0] = 1; sp[1][0] = 6'd17;
        cyc();
        idle();
        chk("wk buffered ready", 64'(fipr[1][0]), 64'd1);
        ipv[0] = 1; ip[0] = 6'd20; ipv[1] = 1; ip[1] = 6'd21;
        spr[3][2] = 1; sp[3][2] = 6'd20;
        push(2'd2, 6'd12, 1'b1, "wk push2");
        cyc();
        idle();
        chk("wk same-cycle ready", 64'(fipr[2][0]), 64'd1);
        chk("wk other slot idle", 64'(fipr[2][1]), 64'd0);

        // Flush drops buffers and a same-cycle offer; pointers survive.
        for (int i = 0; i < NF; i++) cfg[i] = 2'd0;
        do_reset();
        push(2'd0, 6'd1, 1'b1, "fl push1"); cyc();
        push(2'd0, 6'd9, 1'b1, "fl push2"); cyc();
        flush = 1;
        push(2'd0, 6'd2, 1'b0, "fl in_ready");
        cyc();
        idle();
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("fl valid[%0d]", i), 64'(fv[i]), 64'd0);
            chk($sformatf("fl occ[%0d]", i), 64'(occ[i]), 64'd0);
        end
        push(2'd0, 6'd3, 1'b1, "fl push3");
        cyc();
        idle();
        chk("fl rr kept valid2", 64'(fv[2]), 64'd1);
        chk("fl rr kept id", 64'(fid[2]), 64'd3);
        chk("fl rr kept valid0", 64'(fv[0]), 64'd0);

        // Randomized traffic against the model.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < NF; i++)
                cfg[i] = (ph == 0) ? 2'(i) : 2'($urandom_range(3));
            do_reset();
            for (int c = 0; c < 600; c++) begin
                m_check("rnd");
                rand_in();
                #1;
                chk("rnd in_ready", 64'(in_ready), 64'(m_ready()));
                m_step();
                cyc();
            end
            rst = 0;
            idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
